alu_share_arbiter: RTL

Two-port arbiter and sequencer that time-shares the single 32-bit ALU between two requesters, such as the main datapath and a multiply/divide or address-generation helper. It accepts one operation at a time over a valid/ready handshake and arbitrates round-robin when both ports request together. It drives the ALU operand and control inputs from registered state, captures `ALU_Result`/`Zero` one cycle later and returns them on the granted port's response channel. Illegal ALU control codes are rejected with an error flag instead of being issued.

---
 rtl/alu_share_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Time-shares one ALU between two requesters. One operation is in flight at a
// time. Simultaneous requests are arbitrated round-robin.
//
// State | meaning
// IDLE  | pick a port and accept its request
// EXEC  | ALU inputs are driven from the operand registers; result captured
// RESP  | response held on the latched port until consumed
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   reqN_valid/ready/a/b/ctl/imm  request channel for port N (N = 0, 1)
//   rspN_valid/ready/result/zero/err  response channel for port N
//   alu_a/b/ctl/imm               operands and control driven to the ALU
//   alu_result/alu_zero           ALU outputs, sampled at the end of EXEC
//   busy                          high whenever the FSM is not IDLE
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctl,
  input  logic [IMM_W-1:0] req0_imm,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctl,
  input  logic [IMM_W-1:0] req1_imm,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctl,
  output logic [IMM_W-1:0] alu_imm,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic             port_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       ctl_q;
  logic [IMM_W-1:0] imm_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;

  logic             grant;
  logic             handshake;
  logic             rsp_fire;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [3:0]       sel_ctl;
  logic [IMM_W-1:0] sel_imm;

  function automatic logic ctl_legal(input logic [3:0] ctl);
    case (ctl)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1110, 4'b1100: ctl_legal = 1'b1;
      default:                                              ctl_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // On a tie the port that did not win last time goes next.
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = 1'b1;
    if (!reset && state_q == IDLE) begin
      req0_ready = req0_valid && !grant;
      req1_ready = req1_valid && grant;
    end
    handshake = req0_ready || req1_ready;
    sel_a     = grant ? req1_a   : req0_a;
    sel_b     = grant ? req1_b   : req0_b;
    sel_ctl   = grant ? req1_ctl : req0_ctl;
    sel_imm   = grant ? req1_imm : req0_imm;
    rsp_fire  = port_q ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
    case (state_q)
      IDLE:    if (handshake) state_d = ctl_legal(sel_ctl) ? EXEC : RESP;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ctl_q        <= 4'b0000;
      imm_q        <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        last_grant_q <= grant;
        port_q       <= grant;
        // Illegal codes never reach the ALU, so its inputs keep the last
        // issued operation.
        if (ctl_legal(sel_ctl)) begin
          a_q   <= sel_a;
          b_q   <= sel_b;
          ctl_q <= sel_ctl;
          imm_q <= sel_imm;
        end else begin
          result_q <= '0;
          zero_q   <= 1'b0;
          err_q    <= 1'b1;
        end
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
        err_q    <= 1'b0;
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_ctl     = ctl_q;
  assign alu_imm     = imm_q;
  assign rsp0_valid  = (state_q == RESP) && !port_q;
  assign rsp1_valid  = (state_q == RESP) && port_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;
  assign busy        = (state_q != IDLE);

endmodule
